// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL_OP    = 3'd0,
        MULH_OP   = 3'd1,
        MULHSU_OP = 3'd2,
        MULHU_OP  = 3'd3,
        DIV_OP    = 3'd4,
        DIVU_OP   = 3'd5,
        REM_OP    = 3'd6,
        REMU_OP   = 3'd7
    } muldiv_op;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } muldiv_state;

    function automatic logic is_div(input muldiv_op op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op op);
        return op[2] & op[1];
    endfunction

    function automatic logic a_signed(input muldiv_op op);
        return (op == MUL_OP) || (op == MULH_OP) || (op == MULHSU_OP) ||
               (op == DIV_OP) || (op == REM_OP);
    endfunction

    function automatic logic b_signed(input muldiv_op op);
        return (op == MUL_OP) || (op == MULH_OP) || (op == DIV_OP) || (op == REM_OP);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step
// over a {high, low} accumulator of twice the operand width.
module muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   operand_i,
    input  logic                    is_div_i,
    output logic [2*DATA_WIDTH-1:0] acc_o
);

    localparam int W = DATA_WIDTH;

    logic [W:0] add_sum;
    logic [W:0] div_win;
    logic [W:0] div_diff;

    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, consumed LSB first.
        add_sum  = {1'b0, acc_i[2*W-1:W]} + {1'b0, operand_i};
        // Divide: the partial remainder shifted left by one, widened to catch the borrow.
        div_win  = acc_i[2*W-1:W-1];
        div_diff = div_win - {1'b0, operand_i};
        acc_o    = {1'b0, acc_i[2*W-1:1]};
        if (is_div_i) begin
            if (!div_diff[W]) begin
                acc_o = {div_diff[W-1:0], acc_i[W-2:0], 1'b1};
            end else begin
                acc_o = {div_win[W-1:0], acc_i[W-2:0], 1'b0};
            end
        end else if (acc_i[0]) begin
            acc_o = {add_sum, acc_i[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: start/busy/done handshake, one bit per cycle,
// sign fixup in a dedicated cycle, divide special cases resolved at accept, kill for flushes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  kill,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    muldiv_state   state_q;
    muldiv_op      op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]  opnd_q;
    logic          a_neg_q;
    logic          b_neg_q;
    logic [W-1:0]  result_q;
    logic          busy_q;
    logic          done_q;

    muldiv_op      op_in;
    logic          accept;
    logic          a_neg_d;
    logic          b_neg_d;
    logic [W-1:0]  mag_a;
    logic [W-1:0]  mag_b;
    logic [2*W-1:0] acc_d;
    logic [W-1:0]  opnd_d;
    logic          div_zero;
    logic          div_ovf;
    logic          special;
    logic [W-1:0]  special_result;
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] prod;
    logic [W-1:0]  quot;
    logic [W-1:0]  rem;
    logic [W-1:0]  fix_result;

    assign op_in  = muldiv_op'(op);
    assign accept = start && !kill && ((state_q == IDLE) || (state_q == DONE));

    always_comb begin
        a_neg_d  = a_signed(op_in) & op_a[W-1];
        b_neg_d  = b_signed(op_in) & op_b[W-1];
        mag_a    = a_neg_d ? -op_a : op_a;
        mag_b    = b_neg_d ? -op_b : op_b;
        // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
        acc_d    = is_div(op_in) ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
        opnd_d   = is_div(op_in) ? mag_b : mag_a;
        div_zero = is_div(op_in) && (op_b == '0);
        div_ovf  = ((op_in == DIV_OP) || (op_in == REM_OP)) &&
                   (op_a == MOST_NEG) && (op_b == '1);
        special  = div_zero || div_ovf;
        special_result = '0;
        if (is_rem(op_in)) begin
            special_result = div_zero ? op_a : '0;
        end else begin
            special_result = div_zero ? '1 : op_a;
        end
    end

    muldiv_iter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_iter (
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .is_div_i  (is_div(op_q)),
        .acc_o     (acc_step)
    );

    always_comb begin
        prod       = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
        quot       = (a_neg_q ^ b_neg_q) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem        = a_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        fix_result = rem;
        case (op_q)
            MUL_OP:                       fix_result = prod[W-1:0];
            MULH_OP, MULHSU_OP, MULHU_OP: fix_result = prod[2*W-1:W];
            DIV_OP, DIVU_OP:              fix_result = quot;
            default:                      fix_result = rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= MUL_OP;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        cnt_q   <= '0;
                        acc_q   <= acc_d;
                        opnd_q  <= opnd_d;
                        a_neg_q <= a_neg_d;
                        b_neg_q <= b_neg_d;
                        if (special) begin
                            state_q  <= DONE;
                            result_q <= special_result;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            state_q <= CALC;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            state_q <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    busy_q <= 1'b0;
                    if (kill) begin
                        state_q <= IDLE;
                    end else begin
                        state_q  <= DONE;
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] prev_result;

    always #5 clk = ~clk;

    muldiv_unit #(
        .DATA_WIDTH(W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .op_a   (op_a),
        .op_b   (op_b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference RV32M semantics from wide signed/unsigned arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        longint      q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb;
                return q[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                q = ua / ub;
                return q[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = sa % sb;
                return q[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                q = ua % ub;
                return q[31:0];
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
        if (o >= 3'd4 && b == 32'h0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return W + 2;
    endfunction

    // Issue one op and follow it to done; poke>0 pulses a junk start at that cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        int          lat;
        int          busy_cyc;
        int          exp_lat;
        logic [31:0] exp;
        exp     = model(o, a, b);
        exp_lat = model_latency(o, a, b);
        @(negedge clk);
        op = o; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        busy_cyc = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cyc++;
            if (lat == poke) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 7));
                op_a = $urandom;
                op_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("done_seen", {31'h0, done}, 32'h1);
        check("busy_with_done", {31'h0, busy}, 32'h0);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_cyc, exp_lat - 1);
        check("result", result, exp);
        prev_result = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        int          done_cnt;
        logic [31:0] exp1;
        logic [31:0] exp2;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'd0; op_a = '0; op_b = '0;
        prev_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed values
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_7_neg3", result, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        check("mulh_min_min", result, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mulhu_max", result, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        check("mulhsu_neg1_2", result, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg7_2", result, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        check("rem_neg7_2", result, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 0);
        check("divu_100_7", result, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 0);
        check("remu_100_7", result, 32'd2);
        run_op(3'd5, 32'h1234, 32'h0, 0);
        check("divu_by_zero", result, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h1234, 32'h0, 0);
        check("rem_by_zero", result, 32'h1234);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_overflow", result, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("rem_overflow", result, 32'h0);
        run_op(3'd0, 32'h1234_5678, 32'h0, 0);

        // Start pulsed while the unit is busy must not disturb the running op
        run_op(3'd0, 32'h0001_0003, 32'h0000_0005, 5);
        check("start_in_calc_ignored", result, 32'h0005_000F);
        repeat (3) @(posedge clk);
        #1;
        check("no_stray_done", {31'h0, done}, 32'h0);

        // Start held in the DONE cycle issues back to back
        exp1 = model(3'd4, 32'd1000, 32'hFFFF_FFFD);
        exp2 = model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
        @(negedge clk);
        op = 3'd4; op_a = 32'd1000; op_b = 32'hFFFF_FFFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_first_latency", lat, W + 2);
        check("b2b_first_result", result, exp1);
        op = 3'd3; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_done_gap", lat, W + 2);
        check("b2b_second_result", result, exp2);
        prev_result = exp2;

        // Kill together with start in IDLE is not an accept
        repeat (2) @(posedge clk);
        @(negedge clk);
        op = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", {31'h0, busy}, 32'h0);
        check("kill_start_done", {31'h0, done}, 32'h0);

        // Kill in CALC cycle 10
        @(negedge clk);
        op = 3'd5; op_a = 32'hFFFF_0000; op_b = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_kill", {31'h0, busy}, 32'h1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_busy", {31'h0, busy}, 32'h0);
        check("kill_result_kept", result, prev_result);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        check("kill_no_done", done_cnt, 0);
        run_op(3'd7, 32'hFFFF_0000, 32'd13, 0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        op = 3'd1; op_a = $urandom; op_b = $urandom; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        check("arst_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        prev_result = '0;
        run_op(3'd6, 32'hFFFF_FF00, 32'd7, 0);

        // Randomized ops, biased toward the divide corner cases
        for (int n = 0; n < 40; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            run_op(ro, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
